// File: rtl/sequence_player_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sequence_player_pkg
// Description : Shared types and sizes for the sequence player. It holds the
//               playback state encoding, the buffer depth, the segment bus
//               width, the dwell timer width and the buffer pointer width.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package sequence_player_pkg;

  localparam int SEQ_DEPTH = 7;   // entries captured per run (LFSR run length)
  localparam int SEG_W     = 7;   // display / LFSR value width
  localparam int TIMER_W   = 24;  // dwell and gap counter width
  localparam int PTR_W     = 3;   // buffer pointer width; holds 0..SEQ_DEPTH

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RESTART = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_SHOW    = 3'd3,
    ST_GAP     = 3'd4,
    ST_DONE    = 3'd5
  } state_t;

endpackage
`default_nettype wire

// File: rtl/sequence_player_if.sv
`default_nettype none
// ============================================================================
// Module      : sequence_player_if
// Description : Link between the sequence player and the 7-bit LFSR stage.
// Signals     : lfsr_out      - LFSR current value (LFSR -> player)
//               lfsr_complete - LFSR completion flag (LFSR -> player)
//               lfsr_enable   - step enable (player -> LFSR)
//               lfsr_restart  - registered restart pulse (player -> LFSR)
// Modports    : master - the sequence player side
//               slave  - the LFSR side
// Revision    : 1.0 - initial release
// ============================================================================
interface sequence_player_if;
  import sequence_player_pkg::*;

  logic [SEG_W-1:0] lfsr_out;
  logic             lfsr_complete;
  logic             lfsr_enable;
  logic             lfsr_restart;

  modport master (
    input  lfsr_out,
    input  lfsr_complete,
    output lfsr_enable,
    output lfsr_restart
  );

  modport slave (
    output lfsr_out,
    output lfsr_complete,
    input  lfsr_enable,
    input  lfsr_restart
  );

endinterface
`default_nettype wire

// File: rtl/sequence_player_dwell_timer.sv
`default_nettype none
// ============================================================================
// Module      : sequence_player_dwell_timer
// Description : Dwell timer shared by the SHOW and GAP phases. The count is
//               zeroed while i_load is high and otherwise advances by one per
//               cycle; o_expire flags the last cycle of a phase.
// Ports       : clk      - clock, rising edge
//               rst      - asynchronous active-high reset
//               i_load   - zero the counter on the next edge
//               i_limit  - phase length in cycles (1..2^24-1)
//               o_expire - high while the count equals i_limit-1
// Revision    : 1.0 - initial release
// ============================================================================
module sequence_player_dwell_timer
  import sequence_player_pkg::*;
(
  input  wire logic               clk,
  input  wire logic               rst,
  input  wire logic               i_load,
  input  wire logic [TIMER_W-1:0] i_limit,
  output logic                    o_expire
);

  logic [TIMER_W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + TIMER_W'(1);
    end
  end

  // Phase lasts exactly i_limit cycles: counts 0 .. i_limit-1.
  assign o_expire = (r_cnt == (i_limit - TIMER_W'(1)));

endmodule
`default_nettype wire

// File: rtl/sequence_player.sv
`default_nettype none
// ============================================================================
// Module      : sequence_player
// Description : Restarts the LFSR, captures the seven values it steps
//               through into a flop buffer, then replays them on the display
//               bus with a fixed dwell per entry and a blank gap between
//               entries, ending with a one-cycle done pulse.
// Ports       : clk             - clock, rising edge
//               rst             - asynchronous active-high reset
//               i_start         - run request (level, sampled in IDLE only)
//               i_stop          - abort to IDLE from any state
//               lfsr_bus        - LFSR link (master modport)
//               o_display       - segment pattern, zero when not showing
//               o_display_valid - high while an entry is shown
//               o_busy          - high in any state except IDLE
//               o_done          - one-cycle pulse at end of playback
//               o_err           - sticky zero-seed flag
// Revision    : 1.0 - initial release
// ============================================================================
module sequence_player
  import sequence_player_pkg::*;
#(
  parameter int DEPTH        = SEQ_DEPTH,
  parameter int DWELL_CYCLES = 1_000_000,
  parameter int GAP_CYCLES   = 250_000
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             i_start,
  input  wire logic             i_stop,
  sequence_player_if.master     lfsr_bus,
  output logic [SEG_W-1:0]      o_display,
  output logic                  o_display_valid,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_err
);

  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(DEPTH - 1);
  localparam logic [PTR_W-1:0] FULL_IDX = PTR_W'(DEPTH);

  state_t             r_state;
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic               r_lfsr_enable;
  logic               r_lfsr_restart;
  logic [SEG_W-1:0]   r_display;
  logic               r_display_valid;
  logic               r_done;
  logic               r_err;
  logic [SEG_W-1:0]   r_mem [DEPTH];

  logic [PTR_W-1:0]   w_rd_next;
  logic               w_buf_full;
  logic               w_mem_we;
  logic               w_in_phase;
  logic               w_timer_load;
  logic [TIMER_W-1:0] w_limit;
  logic               w_expire;

  assign w_rd_next  = r_rd_ptr + PTR_W'(1);
  assign w_buf_full = (r_wr_ptr == FULL_IDX);

  // A capture edge writes only a legal, nonzero value into a free slot.
  assign w_mem_we = (r_state == ST_CAPTURE) && !i_stop
                 && !lfsr_bus.lfsr_complete && !w_buf_full
                 && (lfsr_bus.lfsr_out != '0);

  // Counter is held at zero outside SHOW/GAP and re-zeroed on each phase
  // boundary, so every SHOW/GAP entry starts counting from 0.
  assign w_in_phase   = (r_state == ST_SHOW) || (r_state == ST_GAP);
  assign w_timer_load = !w_in_phase || w_expire;
  assign w_limit      = (r_state == ST_SHOW) ? TIMER_W'(DWELL_CYCLES)
                                             : TIMER_W'(GAP_CYCLES);

  sequence_player_dwell_timer u_dwell_timer (
    .clk      (clk),
    .rst      (rst),
    .i_load   (w_timer_load),
    .i_limit  (w_limit),
    .o_expire (w_expire)
  );

  // Capture buffer: contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[r_wr_ptr] <= lfsr_bus.lfsr_out;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state         <= ST_IDLE;
      r_wr_ptr        <= '0;
      r_rd_ptr        <= '0;
      r_lfsr_enable   <= 1'b0;
      r_lfsr_restart  <= 1'b0;
      r_display       <= '0;
      r_display_valid <= 1'b0;
      r_done          <= 1'b0;
      r_err           <= 1'b0;
    end else if (i_stop) begin
      // Abort: everything but the sticky error returns to idle values.
      r_state         <= ST_IDLE;
      r_lfsr_enable   <= 1'b0;
      r_lfsr_restart  <= 1'b0;
      r_display       <= '0;
      r_display_valid <= 1'b0;
      r_done          <= 1'b0;
    end else begin
      r_lfsr_restart <= 1'b0;
      r_done         <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_state        <= ST_RESTART;
            r_lfsr_restart <= 1'b1;
            r_err          <= 1'b0;
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
          end
        end
        ST_RESTART: begin
          r_state       <= ST_CAPTURE;
          r_lfsr_enable <= 1'b1;
        end
        ST_CAPTURE: begin
          if (lfsr_bus.lfsr_complete || w_buf_full) begin
            r_state         <= ST_SHOW;
            r_lfsr_enable   <= 1'b0;
            r_display       <= r_mem[r_rd_ptr];
            r_display_valid <= 1'b1;
          end else if (lfsr_bus.lfsr_out == '0) begin
            // A zero seed locks the LFSR; abandon the run.
            r_state       <= ST_IDLE;
            r_lfsr_enable <= 1'b0;
            r_err         <= 1'b1;
          end else begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(1);
          end
        end
        ST_SHOW: begin
          if (w_expire) begin
            r_display       <= '0;
            r_display_valid <= 1'b0;
            if (r_rd_ptr == LAST_IDX) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= ST_GAP;
            end
          end
        end
        ST_GAP: begin
          if (w_expire) begin
            r_state         <= ST_SHOW;
            r_rd_ptr        <= w_rd_next;
            r_display       <= r_mem[w_rd_next];
            r_display_valid <= 1'b1;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign lfsr_bus.lfsr_enable  = r_lfsr_enable;
  assign lfsr_bus.lfsr_restart = r_lfsr_restart;
  assign o_display             = r_display;
  assign o_display_valid       = r_display_valid;
  assign o_busy                = (r_state != ST_IDLE);
  assign o_done                = r_done;
  assign o_err                 = r_err;

endmodule
`default_nettype wire

// File: tb/tb_sequence_player.sv
`default_nettype none
// ============================================================================
// Module      : tb_sequence_player
// Description : Self-checking bench for sequence_player. A behavioural LFSR
//               stand-in feeds the player; expected per-cycle output traces
//               are built from the playback rules (dwell/gap/done timing).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sequence_player;
  import sequence_player_pkg::*;

  localparam int DEPTH = 7;
  localparam int DWELL = 3;
  localparam int GAP   = 2;

  // Observation flags: {valid, done, busy, enable, restart, err}
  localparam logic [5:0] F_IDLE    = 6'b000000;
  localparam logic [5:0] F_RESTART = 6'b001010;
  localparam logic [5:0] F_CAPTURE = 6'b001100;
  localparam logic [5:0] F_SHOW    = 6'b101000;
  localparam logic [5:0] F_GAP     = 6'b001000;
  localparam logic [5:0] F_DONE    = 6'b011000;
  localparam logic [5:0] F_ERR     = 6'b000001;

  typedef logic [6:0] vals_t [DEPTH];

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       i_start = 1'b0;
  logic       i_stop = 1'b0;
  logic [6:0] o_display;
  logic       o_display_valid, o_busy, o_done, o_err;

  int checks = 0;
  int failures = 0;

  sequence_player_if u_if ();

  sequence_player #(
    .DEPTH        (DEPTH),
    .DWELL_CYCLES (DWELL),
    .GAP_CYCLES   (GAP)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .i_start         (i_start),
    .i_stop          (i_stop),
    .lfsr_bus        (u_if),
    .o_display       (o_display),
    .o_display_valid (o_display_valid),
    .o_busy          (o_busy),
    .o_done          (o_done),
    .o_err           (o_err)
  );

  always #5 clk = ~clk;

  // Next value of the upstream 7-bit LFSR (01,02,04,08,10,20,41,...)
  function automatic logic [6:0] lfsr_next(input logic [6:0] v);
    return {v[5:0], v[6] ^ v[5]};
  endfunction

  function automatic vals_t model_seq(input logic [6:0] seed);
    vals_t r;
    logic [6:0] v;
    v = seed;
    for (int i = 0; i < DEPTH; i++) begin
      r[i] = v;
      v = lfsr_next(v);
    end
    return r;
  endfunction

  // LFSR stand-in: seed loaded while in reset, DEPTH-1 steps, then complete.
  logic [6:0] lfsr_seed = 7'h01;
  logic [6:0] lfsr_val;
  int         lfsr_steps;
  logic       lfsr_cpl;
  logic       lfsr_rst;
  assign lfsr_rst = rst | u_if.lfsr_restart;

  always @(posedge clk or posedge lfsr_rst) begin
    if (lfsr_rst) begin
      lfsr_val   <= lfsr_seed;
      lfsr_steps <= 0;
      lfsr_cpl   <= 1'b0;
    end else if (u_if.lfsr_enable && !lfsr_cpl) begin
      if (lfsr_steps == DEPTH - 1) begin
        lfsr_cpl <= 1'b1;
      end else begin
        lfsr_val   <= lfsr_next(lfsr_val);
        lfsr_steps <= lfsr_steps + 1;
      end
    end
  end
  assign u_if.lfsr_out      = lfsr_val;
  assign u_if.lfsr_complete = lfsr_cpl;

  logic [12:0] obs;
  assign obs = {o_display, o_display_valid, o_done, o_busy,
                u_if.lfsr_enable, u_if.lfsr_restart, o_err};

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Full run from start to return-to-IDLE, checked cycle by cycle.
  task automatic run_playback(input logic [6:0] seed, input vals_t vals,
                              input bit hold, input string name);
    logic [12:0] exp_q [$];
    logic [12:0] exp_v;
    int cyc;
    for (int i = 0; i < DEPTH; i++) begin
      repeat (DWELL) exp_q.push_back({vals[i], F_SHOW});
      if (i < DEPTH - 1) repeat (GAP) exp_q.push_back({7'h00, F_GAP});
    end
    exp_q.push_back({7'h00, F_DONE});
    exp_q.push_back({7'h00, F_IDLE});

    lfsr_seed = seed;
    i_start = 1'b1;
    tick();                                   // E0
    if (!hold) i_start = 1'b0;
    checks++;
    if (obs !== {7'h00, F_RESTART}) begin
      failures++;
      $display("FAIL %s restart: got %h expected %h", name, obs, {7'h00, F_RESTART});
    end
    for (int e = 1; e <= 8; e++) begin        // E1..E8
      tick();
      checks++;
      if (obs !== {7'h00, F_CAPTURE}) begin
        failures++;
        $display("FAIL %s capture E%0d: got %h expected %h", name, e, obs, {7'h00, F_CAPTURE});
      end
    end
    cyc = 0;
    while (exp_q.size() > 0) begin            // from E9 on
      exp_v = exp_q.pop_front();
      tick();
      checks++;
      if (obs !== exp_v) begin
        failures++;
        $display("FAIL %s playback cycle %0d after SHOW: got %h expected %h", name, cyc, obs, exp_v);
      end
      cyc++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) tick();
    checks++;
    if (obs !== 13'h0) begin
      failures++;
      $display("FAIL reset_hold: got %h expected %h", obs, 13'h0);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (obs !== 13'h0) begin
      failures++;
      $display("FAIL reset_release: got %h expected %h", obs, 13'h0);
    end
  endtask

  task automatic test_known_seed;
    vals_t plan;
    plan = '{7'h01, 7'h02, 7'h04, 7'h08, 7'h10, 7'h20, 7'h41};
    run_playback(7'h01, plan, 1'b0, "seed01");
  endtask

  task automatic test_random_runs;
    logic [6:0] seed;
    for (int r = 0; r < 3; r++) begin
      repeat ($urandom_range(0, 3)) tick();
      seed = 7'($urandom_range(1, 127));
      run_playback(seed, model_seq(seed), 1'b0, "random");
    end
  endtask

  task automatic test_zero_seed;
    logic [6:0] seed;
    lfsr_seed = 7'h00;
    i_start = 1'b1;
    tick();                                   // E0
    i_start = 1'b0;
    checks++;
    if (obs !== {7'h00, F_RESTART}) begin
      failures++;
      $display("FAIL zero_seed E0: got %h expected %h", obs, {7'h00, F_RESTART});
    end
    tick();                                   // E1
    tick();                                   // E2: zero value seen
    for (int c = 0; c < 6; c++) begin
      checks++;
      if (obs !== {7'h00, F_ERR}) begin
        failures++;
        $display("FAIL zero_seed err idle %0d: got %h expected %h", c, obs, {7'h00, F_ERR});
      end
      tick();
    end
    // next accepted start clears err and runs normally
    seed = 7'($urandom_range(1, 127));
    run_playback(seed, model_seq(seed), 1'b0, "after_err");
  endtask

  task automatic test_stop_mid_show;
    logic [6:0] seed;
    vals_t vals;
    int idx, off;
    seed = 7'($urandom_range(1, 127));
    vals = model_seq(seed);
    lfsr_seed = seed;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    repeat (8) tick();
    idx = int'($urandom_range(0, DEPTH - 1));
    off = int'($urandom_range(0, DWELL - 1));
    repeat (idx * (DWELL + GAP) + off + 1) tick();
    checks++;
    if (obs !== {vals[idx], F_SHOW}) begin
      failures++;
      $display("FAIL stop pre_show idx %0d: got %h expected %h", idx, obs, {vals[idx], F_SHOW});
    end
    i_stop = 1'b1;
    tick();
    i_stop = 1'b0;
    checks++;
    if (obs !== 13'h0) begin
      failures++;
      $display("FAIL stop_abort: got %h expected %h", obs, 13'h0);
    end
    tick();
    checks++;
    if (obs !== 13'h0) begin
      failures++;
      $display("FAIL stop_stays_idle: got %h expected %h", obs, 13'h0);
    end
    seed = 7'($urandom_range(1, 127));
    run_playback(seed, model_seq(seed), 1'b0, "after_stop");
  endtask

  task automatic test_start_held;
    logic [6:0] seed;
    seed = 7'($urandom_range(1, 127));
    run_playback(seed, model_seq(seed), 1'b1, "start_held");
    tick();                                   // IDLE sees held start
    checks++;
    if (obs !== {7'h00, F_RESTART}) begin
      failures++;
      $display("FAIL start_held rerun: got %h expected %h", obs, {7'h00, F_RESTART});
    end
    i_start = 1'b0;
    i_stop = 1'b1;
    tick();
    i_stop = 1'b0;
    checks++;
    if (obs !== 13'h0) begin
      failures++;
      $display("FAIL start_held abort: got %h expected %h", obs, 13'h0);
    end
  endtask

  task automatic test_start_stop_together;
    i_start = 1'b1;
    i_stop = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++;
      if (obs !== 13'h0) begin
        failures++;
        $display("FAIL start_stop cycle %0d: got %h expected %h", c, obs, 13'h0);
      end
    end
    i_start = 1'b0;
    i_stop = 1'b0;
  endtask

  task automatic test_async_reset;
    lfsr_seed = 7'($urandom_range(1, 127));
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    repeat (3) tick();                        // mid-CAPTURE
    checks++;
    if (obs !== {7'h00, F_CAPTURE}) begin
      failures++;
      $display("FAIL async_rst pre: got %h expected %h", obs, {7'h00, F_CAPTURE});
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (obs !== 13'h0) begin
      failures++;
      $display("FAIL async_rst immediate: got %h expected %h", obs, 13'h0);
    end
    @(negedge clk);
    rst = 1'b0;
    tick();
    checks++;
    if (obs !== 13'h0) begin
      failures++;
      $display("FAIL async_rst after: got %h expected %h", obs, 13'h0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_known_seed();
    test_random_runs();
    test_zero_seed();
    test_stop_mid_show();
    test_start_held();
    test_start_stop_together();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
